// File: rtl/eci_dcs_defs.sv
// rtl/eci_dcs_defs.sv - shared AXI response codes and DCS memory responder state encodings
package eci_dcs_defs;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_e;

endpackage

// File: rtl/dcs_axi_bram.sv
// rtl/dcs_axi_bram.sv - simple dual-port, read-first, byte-enable RAM with a 1-cycle registered read
module dcs_axi_bram #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 4096,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Non-blocking read and write in one process gives read-first on a same-index collision.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/dcs_axi_mem_responder.sv
// rtl/dcs_axi_mem_responder.sv - AXI4 INCR burst slave backed by on-chip RAM
// Optional DCS_AXI_MEM_DECERR_EN: out-of-range addresses answer DECERR instead of aliasing.
module dcs_axi_mem_responder
    import eci_dcs_defs::*;
#(
    parameter int AXI_ID_WIDTH   = 7,
    parameter int AXI_ADDR_WIDTH = 38,
    parameter int AXI_DATA_WIDTH = 512,
    parameter int MEM_DEPTH      = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready
);

    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int IDX_W          = $clog2(MEM_DEPTH);

    rd_state_e                 rd_state_q, rd_state_d;
    logic [AXI_ID_WIDTH-1:0]   rd_id_q;
    logic [IDX_W-1:0]          rd_idx_q;
    logic [7:0]                rd_len_q, rd_cnt_q;
    logic                      rd_done_q, rd_err_q, pend_q, pend_last_q;
    logic [AXI_DATA_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]                fifo_resp_q [2];
    logic [1:0]                fifo_last_q;
    logic                      fifo_wptr_q, fifo_rptr_q;
    logic [1:0]                fifo_cnt_q;

    wr_state_e                 wr_state_q, wr_state_d;
    logic [AXI_ID_WIDTH-1:0]   wr_id_q;
    logic [IDX_W-1:0]          wr_idx_q;
    logic [7:0]                wr_len_q, wr_cnt_q;
    logic                      wr_err_q;
    logic [1:0]                wr_resp_q;

    logic                      ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic                      rd_issue, rd_issue_last, ram_we;
    logic                      ar_err, aw_err, unused_bits;
    logic [IDX_W-1:0]          ram_raddr, ram_waddr;
    logic [AXI_DATA_WIDTH-1:0] ram_rdata;

`ifdef DCS_AXI_MEM_DECERR_EN
    assign ar_err      = |s_axi_araddr[AXI_ADDR_WIDTH-1:IDX_W+6];
    assign aw_err      = |s_axi_awaddr[AXI_ADDR_WIDTH-1:IDX_W+6];
    assign unused_bits = ^{s_axi_araddr[5:0], s_axi_awaddr[5:0], s_axi_wlast};
`else
    assign ar_err      = 1'b0;
    assign aw_err      = 1'b0;
    assign unused_bits = ^{s_axi_araddr[AXI_ADDR_WIDTH-1:IDX_W+6], s_axi_araddr[5:0],
                           s_axi_awaddr[AXI_ADDR_WIDTH-1:IDX_W+6], s_axi_awaddr[5:0], s_axi_wlast};
`endif

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;
    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign b_hs  = s_axi_bvalid && s_axi_bready;

    // Issue a RAM read only while skid entries plus the in-flight read leave room after this cycle's pop.
    assign rd_issue      = (rd_state_q == RD_BURST) && !rd_done_q &&
                           (({1'b0, fifo_cnt_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, r_hs}));
    assign rd_issue_last = (rd_cnt_q == rd_len_q);
    assign ram_raddr     = rd_idx_q + IDX_W'(rd_cnt_q);
    assign ram_waddr     = wr_idx_q + IDX_W'(wr_cnt_q);
    assign ram_we        = w_hs && !wr_err_q;

    assign s_axi_rvalid = (fifo_cnt_q != 2'd0);
    assign s_axi_rid    = rd_id_q;
    assign s_axi_rdata  = fifo_data_q[fifo_rptr_q];
    assign s_axi_rresp  = fifo_resp_q[fifo_rptr_q];
    assign s_axi_rlast  = s_axi_rvalid && fifo_last_q[fifo_rptr_q];
    assign s_axi_bid    = wr_id_q;
    assign s_axi_bresp  = wr_resp_q;

    dcs_axi_bram #(
        .DATA_W (AXI_DATA_WIDTH),
        .DEPTH  (MEM_DEPTH)
    ) u_bram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (s_axi_wdata),
        .wstrb_i (s_axi_wstrb),
        .re_i    (rd_issue),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
        end
    end

    always_comb begin
        rd_state_d    = rd_state_q;
        s_axi_arready = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) rd_state_d = RD_BURST;
            end
            RD_BURST: if (r_hs && s_axi_rlast) rd_state_d = RD_IDLE;
            default:  rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d    = wr_state_q;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) wr_state_d = WR_DATA;
            end
            WR_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && (wr_cnt_q == wr_len_q)) wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_id_q     <= '0;
            rd_idx_q    <= '0;
            rd_len_q    <= '0;
            rd_cnt_q    <= '0;
            rd_done_q   <= 1'b0;
            rd_err_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            fifo_data_q <= '{default: '0};
            fifo_resp_q <= '{default: '0};
            fifo_last_q <= '0;
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= '0;
        end else begin
            if (ar_hs) begin
                rd_id_q   <= s_axi_arid;
                rd_idx_q  <= s_axi_araddr[IDX_W+5:6];
                rd_len_q  <= s_axi_arlen;
                rd_cnt_q  <= '0;
                rd_done_q <= 1'b0;
                rd_err_q  <= ar_err;
            end else if (rd_issue) begin
                rd_cnt_q  <= rd_cnt_q + 8'd1;
                rd_done_q <= rd_issue_last;
            end
            pend_q      <= rd_issue;
            pend_last_q <= rd_issue && rd_issue_last;
            if (pend_q) begin
                fifo_data_q[fifo_wptr_q] <= rd_err_q ? '0 : ram_rdata;
                fifo_resp_q[fifo_wptr_q] <= rd_err_q ? AXI_RESP_DECERR : AXI_RESP_OKAY;
                fifo_last_q[fifo_wptr_q] <= pend_last_q;
                fifo_wptr_q              <= ~fifo_wptr_q;
            end
            if (r_hs) fifo_rptr_q <= ~fifo_rptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, pend_q} - {1'b0, r_hs};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_id_q   <= '0;
            wr_idx_q  <= '0;
            wr_len_q  <= '0;
            wr_cnt_q  <= '0;
            wr_err_q  <= 1'b0;
            wr_resp_q <= AXI_RESP_OKAY;
        end else begin
            if (aw_hs) begin
                wr_id_q   <= s_axi_awid;
                wr_idx_q  <= s_axi_awaddr[IDX_W+5:6];
                wr_len_q  <= s_axi_awlen;
                wr_cnt_q  <= '0;
                wr_err_q  <= aw_err;
                wr_resp_q <= aw_err ? AXI_RESP_DECERR : AXI_RESP_OKAY;
            end else if (w_hs) begin
                wr_cnt_q  <= wr_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dcs_axi_mem_responder.sv
// tb/tb_dcs_axi_mem_responder.sv - directed scoreboard bench for dcs_axi_mem_responder
module tb_dcs_axi_mem_responder;

    localparam int MEM_DEPTH = 4096;

    typedef struct {
        logic [6:0]   id;
        logic [511:0] data;
        logic         last;
        logic [1:0]   resp;
    } rbeat_t;

    typedef struct {
        logic [6:0] id;
        logic [1:0] resp;
    } bexp_t;

    logic         clk, reset;
    logic [6:0]   arid, rid, awid, bid;
    logic [37:0]  araddr, awaddr;
    logic [7:0]   arlen, awlen;
    logic         arvalid, arready, rvalid, rready, rlast;
    logic [511:0] rdata, wdata;
    logic [1:0]   rresp, bresp;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [63:0]  wstrb;

    int           n_checks = 0;
    int           n_fail   = 0;
    rbeat_t       rq[$];
    bexp_t        bq[$];
    logic [511:0] model [int];
    logic [511:0] wbeat [8];
    logic [63:0]  wstrbv [8];

    dcs_axi_mem_responder u_dut (
        .clk(clk), .reset(reset),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_dec(input logic [37:0] a);
`ifdef DCS_AXI_MEM_DECERR_EN
        return |a[37:18];
`else
        return a[37] & 1'b0;
`endif
    endfunction

    function automatic int line_idx(input logic [37:0] a, input int b);
        return (int'(a[31:6]) + b) % MEM_DEPTH;
    endfunction

    task automatic idle_checks();
        check("rst_arready", arready, 1);
        check("rst_awready", awready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rid", rid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", rresp, 0);
        check("rst_bid", bid, 0);
        check("rst_bresp", bresp, 0);
    endtask

    task automatic axi_write(input logic [6:0] id, input logic [37:0] addr, input logic [7:0] len);
        bexp_t        e;
        int           t;
        int           idx;
        logic         dec;
        logic [511:0] line;
        dec    = is_dec(addr);
        e.id   = id;
        e.resp = dec ? 2'b11 : 2'b00;
        bq.push_back(e);
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!awready && t < 50);
        check("aw_ready", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = wbeat[b]; wstrb = wstrbv[b]; wlast = (b == int'(len));
            t = 0;
            do begin @(negedge clk); t++; end while (!wready && t < 50);
            check("w_ready", wready, 1);
            if (b == 0) check("aw_busy", awready, 0);
            @(posedge clk); #1;
            if (!dec) begin
                idx  = line_idx(addr, b);
                line = model.exists(idx) ? model[idx] : '0;
                for (int k = 0; k < 64; k++)
                    if (wstrbv[b][k]) line[k*8 +: 8] = wbeat[b][k*8 +: 8];
                model[idx] = line;
            end
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        @(negedge clk);
        check("bvalid_next_cycle", bvalid, 1);
        if (bq.size() == 0) check("bq_nonempty", 0, 1);
        else begin
            e = bq.pop_front();
            check("bid", bid, e.id);
            check("bresp", bresp, e.resp);
        end
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("bvalid_clear", bvalid, 0);
        check("aw_ready_back", awready, 1);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [6:0] id, input logic [37:0] addr, input logic [7:0] len,
                            input bit toggle);
        rbeat_t       e;
        int           t, got, edges;
        bit           seen, held;
        logic [511:0] hdata;
        logic         dec;
        dec = is_dec(addr);
        for (int b = 0; b <= int'(len); b++) begin
            e.id   = id;
            e.data = dec ? 512'd0 : model[line_idx(addr, b)];
            e.last = (b == int'(len));
            e.resp = dec ? 2'b11 : 2'b00;
            rq.push_back(e);
        end
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 50);
        check("ar_ready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        got = 0; edges = 0; seen = 0; held = 0; hdata = '0;
        while (got <= int'(len) && edges < 200) begin
            rready = toggle ? (edges % 2 == 0) : 1'b1;
            @(negedge clk);
            if (held) check("r_valid_held", rvalid, 1);
            if (rvalid) begin
                if (!seen) begin check("rd_latency", edges, 2); seen = 1; end
                if (held) check("r_payload_stable", rdata, hdata);
                check("ar_busy", arready, 0);
                if (rready) begin
                    if (rq.size() == 0) check("rq_nonempty", 0, 1);
                    else begin
                        e = rq.pop_front();
                        check("rid", rid, e.id);
                        check("rdata", rdata, e.data);
                        check("rlast", rlast, e.last);
                        check("rresp", rresp, e.resp);
                    end
                    got++;
                    held = 0;
                end else begin
                    held  = 1;
                    hdata = rdata;
                end
            end
            @(posedge clk); #1;
            edges++;
        end
        rready = 1'b0;
        check("rd_beats", got, int'(len) + 1);
        @(negedge clk);
        check("ar_ready_back", arready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        for (int i = 0; i < 8; i++) begin wbeat[i] = '0; wstrbv[i] = '1; end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        idle_checks();
        @(posedge clk); #1;

        wbeat[0] = {64{8'hA5}};
        axi_write(7'd5, 38'h80, 8'd0);
        axi_read(7'd5, 38'h80, 8'd0, 1'b0);

        wbeat[0] = {64{8'h11}};
        wbeat[1] = {64{8'h22}};
        axi_write(7'd6, 38'h1000, 8'd1);
        axi_read(7'd6, 38'h1000, 8'd1, 1'b0);

        for (int b = 0; b < 8; b++) wbeat[b] = {16{32'hC0DE0000 + 32'(b)}};
        axi_write(7'd7, 38'h2000, 8'd7);
        axi_read(7'd7, 38'h2000, 8'd7, 1'b1);

        wbeat[0] = {64{8'h77}};
        wbeat[1] = {64{8'h88}};
        axi_write(7'd8, 38'((MEM_DEPTH - 1) * 64), 8'd1);
        axi_read(7'd8, 38'((MEM_DEPTH - 1) * 64), 8'd1, 1'b0);
        axi_read(7'd8, 38'h0, 8'd0, 1'b0);

        wbeat[0] = '1;
        axi_write(7'd1, 38'h3000, 8'd0);
        wbeat[0]  = {16{32'hDEADBEEF}};
        wstrbv[0] = 64'h0F;
        axi_write(7'd1, 38'h3000, 8'd0);
        wstrbv[0] = '1;
        axi_read(7'd1, 38'h3000, 8'd0, 1'b0);
        check("partial_strobe_line", model[192], {{60{8'hFF}}, 32'hDEADBEEF});

        arid = 7'd9; araddr = 38'h2000; arlen = 8'd7; arvalid = 1'b1;
        @(negedge clk);
        check("mid_ar_ready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_rvalid_pending", rvalid, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        idle_checks();
        @(posedge clk); #1;
        axi_read(7'd10, 38'h1000, 8'd1, 1'b0);

`ifdef DCS_AXI_MEM_DECERR_EN
        wbeat[0] = {64{8'h5A}};
        axi_write(7'd3, 38'h20_0000_0080, 8'd0);
        axi_read(7'd3, 38'h20_0000_0080, 8'd1, 1'b0);
        axi_read(7'd5, 38'h80, 8'd0, 1'b0);
`endif

        check("rq_drained", rq.size(), 0);
        check("bq_drained", bq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
